// File: rtl/tdcv2_pkg.sv
// tdcv2_pkg
//   Shared constants for the TDCV2 channel-word datapath: the error-fill tag
//   and the bit positions of the fields inside a 32b channel hit word
//   {chnum[31:27], mode[26:25], leading[24:8], width[7:0]}.
package tdcv2_pkg;

    localparam logic [7:0] ERROR_WORD_FILL = 8'hE8;

    // Error words carry the fill tag in the top byte.
    localparam int ERRTAG_MSB  = 31;
    localparam int ERRTAG_LSB  = 24;

    localparam int CHNUM_MSB   = 31;
    localparam int CHNUM_LSB   = 27;
    localparam int MODE_MSB    = 26;
    localparam int MODE_LSB    = 25;
    localparam int LEADING_MSB = 24;
    localparam int LEADING_LSB = 8;
    localparam int WIDTH_MSB   = 7;
    localparam int WIDTH_LSB   = 0;

    function automatic logic is_error_word(input logic [31:0] w);
        return w[ERRTAG_MSB:ERRTAG_LSB] == ERROR_WORD_FILL;
    endfunction

endpackage

// File: rtl/tdcv2_sync_fifo.sv
// tdcv2_sync_fifo
//   Single-clock RAM FIFO, 2**DEPTH_LOG2 entries, with an occupancy output.
//   The head entry is presented combinationally; the consumer registers it
//   when it pops, so the read is registered one level up.
// Ports
//   clk, rst    clock, synchronous active-high reset (pointers/level only)
//   push, data  write request; ignored when full
//   pop         read request; ignored when empty
//   head        entry at the read pointer
//   level       number of stored entries (0 .. 2**DEPTH_LOG2)
//   full, empty occupancy flags
module tdcv2_sync_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // level never exceeds DEPTH, so its MSB alone marks "full".
    assign full    = level[DEPTH_LOG2];
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

    // Pointers wrap naturally at 2**DEPTH_LOG2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level <= level + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/tdcv2_hit_buffer.sv
// tdcv2_hit_buffer
//   Takes channel words from the TDCV2 channel aligner, classifies them as
//   hit or error-fill words, drops hits from masked channels, buffers the
//   rest in a FIFO and hands them to the event builder over valid/ready.
//   Saturating hit/error/drop counters are kept for slow control.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            accept input words when 1; output keeps draining when 0
//   chnl_data_valid   input strobe (no backpressure upstream)
//   chnl_data_32b     channel word
//   chnl_mask         per-channel hit mask (1 = drop); error words unaffected
//   clear_cnt         zero all counters and overflow_sticky
//   out_valid/ready   output handshake
//   out_data          buffered word, unmodified
//   out_is_error      out_data is an error-fill word
//   fifo_level        FIFO occupancy, output register excluded
//   overflow_sticky   a word was lost to a full FIFO since last clear
//   hit_cnt/err_cnt   words written to the FIFO, by class
//   drop_cnt          words lost to a full FIFO
module tdcv2_hit_buffer
    import tdcv2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  chnl_data_valid,
    input  logic [31:0]           chnl_data_32b,
    input  logic [31:0]           chnl_mask,
    input  logic                  clear_cnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_is_error,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow_sticky,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);
    logic        word_is_err;
    logic [4:0]  chnum;
    logic        masked;
    logic        accept;
    logic        push;
    logic        drop;
    logic        load;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign word_is_err = is_error_word(chnl_data_32b);
    assign chnum       = chnl_data_32b[CHNUM_MSB:CHNUM_LSB];
    assign masked      = ~word_is_err & chnl_mask[chnum];
    assign accept      = chnl_data_valid & enable & ~masked;
    // Fullness is judged before any same-cycle pop, so a word arriving
    // while full is lost even if the output side is draining.
    assign push        = accept & ~fifo_full;
    assign drop        = accept & fifo_full;
    assign load        = ~fifo_empty & (~out_valid | out_ready);

    tdcv2_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .data  (chnl_data_32b),
        .pop   (load),
        .head  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register: refills from the FIFO head whenever it is free or
    // being consumed; holds its contents while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_is_error <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_data     <= fifo_head;
            out_is_error <= is_error_word(fifo_head);
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Statistics: clear_cnt takes priority over a coincident event.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
            hit_cnt         <= '0;
            err_cnt         <= '0;
            drop_cnt        <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (push && !word_is_err) hit_cnt  <= sat_inc(hit_cnt);
            if (push &&  word_is_err) err_cnt  <= sat_inc(err_cnt);
            if (drop) begin
                drop_cnt        <= sat_inc(drop_cnt);
                overflow_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdcv2_hit_buffer.sv
module tb_tdcv2_hit_buffer;
    localparam int DL    = 6;
    localparam int DEPTH = 64;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          chnl_data_valid;
    logic [31:0]   chnl_data_32b;
    logic [31:0]   chnl_mask;
    logic          clear_cnt;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_is_error;
    logic [DL:0]   fifo_level;
    logic          overflow_sticky;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] drop_cnt;

    tdcv2_hit_buffer #(.DEPTH_LOG2(DL), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .chnl_data_valid (chnl_data_valid),
        .chnl_data_32b   (chnl_data_32b),
        .chnl_mask       (chnl_mask),
        .clear_cnt       (clear_cnt),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_is_error    (out_is_error),
        .fifo_level      (fifo_level),
        .overflow_sticky (overflow_sticky),
        .hit_cnt         (hit_cnt),
        .err_cnt         (err_cnt),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: buffered words as a queue plus one output slot.
    logic [31:0] m_fifo[$];
    logic [31:0] sb[$];      // every word written, in order, for the consumer
    logic        m_ov;
    logic [31:0] m_od;
    logic [31:0] m_hit, m_err, m_drop;
    logic        m_sticky;

    function automatic logic [31:0] inc_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        sb.delete();
        m_ov = 0; m_od = 0;
        m_hit = 0; m_err = 0; m_drop = 0; m_sticky = 0;
    endtask

    // One clock: update the model from the pre-edge inputs, then compare.
    task automatic cycle();
        logic        pv;
        logic [31:0] pd;
        logic        hs, is_err, msk, acc, full, pop, stalled;
        logic [31:0] w;
        pv = out_valid;
        pd = out_data;
        @(posedge clk);
        hs      = pv && out_ready;
        stalled = pv && !out_ready && !rst;
        w       = chnl_data_32b;
        if (rst) begin
            model_reset();
        end else begin
            if (hs) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else chk("sb_order", pd, sb.pop_front());
            end
            is_err = (w[31:24] == 8'hE8);
            msk    = !is_err && chnl_mask[w[31:27]];
            acc    = chnl_data_valid && enable && !msk;
            full   = (m_fifo.size() == DEPTH);
            pop    = (m_fifo.size() != 0) && (!m_ov || out_ready);
            if (pop) begin
                m_od = m_fifo.pop_front();
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (acc && !full) begin
                m_fifo.push_back(w);
                sb.push_back(w);
                if (is_err) m_err = inc_sat(m_err);
                else        m_hit = inc_sat(m_hit);
            end
            if (acc && full) begin
                m_drop   = inc_sat(m_drop);
                m_sticky = 1;
            end
            if (clear_cnt) begin
                m_hit = 0; m_err = 0; m_drop = 0; m_sticky = 0;
            end
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("fifo_level", fifo_level, m_fifo.size());
        chk("hit_cnt", hit_cnt, m_hit);
        chk("err_cnt", err_cnt, m_err);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("overflow_sticky", overflow_sticky, m_sticky);
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_is_error", out_is_error, m_od[31:24] == 8'hE8);
        end
        if (stalled) chk("stall_hold", out_data, pd);
    endtask

    function automatic logic [31:0] mk_hit(input int ch);
        logic [4:0] c;
        c = ch[4:0];
        return {c, 2'b01, 17'($urandom), 8'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 5) == 0) return {8'hE8, 24'($urandom)};
        return $urandom;
    endfunction

    task automatic idle_in();
        chnl_data_valid = 0;
        clear_cnt = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        chnl_data_valid = 1;
        chnl_data_32b = w;
        cycle();
        chnl_data_valid = 0;
    endtask

    task automatic drain(input int n);
        out_ready = 1;
        idle_in();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1; enable = 1; chnl_data_valid = 0; chnl_data_32b = 0;
        chnl_mask = 0; clear_cnt = 0; out_ready = 1;
        model_reset();
        cycle(); cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        rst = 0;

        // 1: three hits back to back, latency and order
        chnl_data_valid = 1; chnl_data_32b = mk_hit(0);
        cycle();
        chk("lat_n1", out_valid, 0);
        chnl_data_32b = mk_hit(5);
        cycle();
        chk("lat_n2", out_valid, 1);
        chnl_data_32b = mk_hit(31);
        cycle();
        chnl_data_valid = 0;
        drain(5);
        chk("t1_hit_cnt", hit_cnt, 3);
        chk("t1_sb_empty", sb.size(), 0);

        // 2: error word bypasses mask; masked hits vanish without counting
        chnl_mask = 32'hFFFF_FFFF;
        push_word(32'hE880_E500);
        for (int i = 0; i < 3; i++) push_word(mk_hit(5));
        drain(4);
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_drop_cnt", drop_cnt, 0);
        chk("t2_hit_cnt", hit_cnt, 3);
        chnl_mask = 0;

        // 3: overflow with stalled consumer
        out_ready = 0;
        for (int i = 0; i < DEPTH + 4; i++) push_word(mk_hit(i % 32));
        chk("t3_level_full", fifo_level, DEPTH);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_drop_cnt", drop_cnt, 3);
        chk("t3_sticky", overflow_sticky, 1);
        out_ready = 1;
        push_word(mk_hit(7));   // pop and push together while full
        chk("t3_pushpop_drop", drop_cnt, 4);
        chk("t3_pushpop_level", fifo_level, DEPTH - 1);
        drain(DEPTH + 4);
        chk("t3_sb_empty", sb.size(), 0);

        // 4: burst against a consumer toggling ready every clock
        for (int i = 0; i < 20; i++) begin
            out_ready = i[0];
            push_word(rnd_word());
        end
        for (int i = 0; i < 60; i++) begin
            out_ready = i[0];
            cycle();
        end
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_level", fifo_level, 0);

        // 5: saturation and clear priority
        out_ready = 1;
        force dut.hit_cnt = 32'hFFFF_FFFF;
        #1 release dut.hit_cnt;
        m_hit = 32'hFFFF_FFFF;
        push_word(mk_hit(3));
        chk("t5_hit_sat", hit_cnt, 32'hFFFF_FFFF);
        clear_cnt = 1;
        push_word(mk_hit(4));
        clear_cnt = 0;
        chk("t5_clear_wins", hit_cnt, 0);
        drain(4);

        // 6: reset mid-stream, then strobes while disabled
        out_ready = 0;
        for (int i = 0; i < 10; i++) push_word(mk_hit(i));
        rst = 1;
        cycle();
        rst = 0;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_level", fifo_level, 0);
        enable = 0;
        for (int i = 0; i < 5; i++) push_word(rnd_word());
        chk("t6_dis_level", fifo_level, 0);
        chk("t6_dis_hit", hit_cnt, 0);
        enable = 1;

        // Random traffic: bursts of stall to provoke overflow, rare clears/resets
        for (int i = 0; i < 3000; i++) begin
            chnl_data_valid = ($urandom_range(0, 3) != 0);
            chnl_data_32b   = rnd_word();
            enable          = ($urandom_range(0, 15) != 0);
            clear_cnt       = ($urandom_range(0, 199) == 0);
            rst             = ($urandom_range(0, 999) == 0);
            if ((i % 200) == 0) chnl_mask = $urandom & $urandom & $urandom;
            if ((i / 150) % 3 == 1) out_ready = ($urandom_range(0, 7) == 0);
            else                    out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rst = 0; enable = 1;
        drain(DEPTH + 4);
        chk("rand_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
